// File: rtl/ram_march_tester.sv
// March BIST engine for a single-port RAM with registered read data.
// Runs W(bg); up R(bg)W(~bg); down R(~bg)W(bg); up R(bg) and reports the result.
module ram_march_tester #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        fail_cnt,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    IDLE, W0, RW1_RD, RW1_WR, RW0_RD, RW0_WR, R0_RD, R0_CHK, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle
  // pulse one cycle after the last compare, with pass valid in that same cycle.
  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                cmp_en;
  logic [DATA_W-1:0]   exp_data;
  logic                mismatch;
  logic [7:0]          fail_cnt_nxt;
  logic                we_nxt;
  logic [DATA_W-1:0]   din_nxt;
  logic                busy_nxt;

  assign ram_addr  = addr_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    cmp_en    = 1'b0;
    exp_data  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = W0;
          addr_nxt  = '0;
        end
      end
      W0: begin
        if (addr_q == ADDR_MAX) begin
          state_nxt = RW1_RD;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr_q + 1'b1;
        end
      end
      RW1_RD: state_nxt = RW1_WR;
      RW1_WR: begin
        cmp_en   = 1'b1;
        exp_data = BG;
        if (addr_q == ADDR_MAX) begin
          state_nxt = RW0_RD;
          addr_nxt  = ADDR_MAX;
        end else begin
          state_nxt = RW1_RD;
          addr_nxt  = addr_q + 1'b1;
        end
      end
      RW0_RD: state_nxt = RW0_WR;
      RW0_WR: begin
        cmp_en   = 1'b1;
        exp_data = ~BG;
        if (addr_q == '0) begin
          state_nxt = R0_RD;
        end else begin
          state_nxt = RW0_RD;
          addr_nxt  = addr_q - 1'b1;
        end
      end
      R0_RD: state_nxt = R0_CHK;
      R0_CHK: begin
        cmp_en   = 1'b1;
        exp_data = BG;
        if (addr_q == ADDR_MAX) begin
          state_nxt = DONE;
        end else begin
          state_nxt = R0_RD;
          addr_nxt  = addr_q + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // RAM pin values for the cycle the FSM is entering, so they register with it.
  always_comb begin
    we_nxt   = 1'b0;
    din_nxt  = '0;
    busy_nxt = 1'b1;
    case (state_nxt)
      W0:     begin we_nxt = 1'b1; din_nxt = BG;  end
      RW1_WR: begin we_nxt = 1'b1; din_nxt = ~BG; end
      RW0_WR: begin we_nxt = 1'b1; din_nxt = BG;  end
      IDLE, DONE: busy_nxt = 1'b0;
      default: ;
    endcase
  end

  // fail_cnt saturates and never returns to zero within a run, so zero marks "no mismatch yet".
  assign mismatch     = cmp_en && (ram_dout != exp_data);
  assign fail_cnt_nxt = (mismatch && fail_cnt != 8'hFF) ? fail_cnt + 8'd1 : fail_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      ram_we  <= we_nxt;
      ram_din <= din_nxt;
      busy    <= busy_nxt;
      done    <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_cnt  <= '0;
      end else begin
        fail_cnt <= fail_cnt_nxt;
        if (mismatch && fail_cnt == 8'd0) begin
          fail_addr <= addr_q;
          fail_data <= ram_dout;
        end
        if (state_nxt == DONE) pass <= (fail_cnt_nxt == 8'd0);
      end
    end
  end

endmodule
